fp6_mult_rr_scheduler: RTL and testbench
========================================

// Module: fp6_mult_rr_scheduler
// PURPOSE
//  Shares one fp6_mult datapath among NUM_REQ requesters in the FP6 compute array.
//  Round-robin arbiter picks one request per cycle; operands are registered (S1),
//  multiplied combinationally by an fp6_mult instance, and the result is registered (S2).
//  Each result is tagged with its requester ID. Full valid/ready backpressure on both sides.
// PARAMETERS
//  NUM_REQ  4                        number of requesters (>=2)
//  ID_W     $clog2(NUM_REQ)          width of requester ID tag
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NUM_REQ    per-requester operand valid
//  req_ready  out  NUM_REQ    per-requester accept; one-hot or zero
//  req_a      in   NUM_REQ*6  FP6 operand A, requester i in [6*i+5:6*i]
//  req_b      in   NUM_REQ*6  FP6 operand B, same packing
//  rsp_valid  out  1          result valid (S2 occupied)
//  rsp_ready  in   1          downstream accepts result
//  rsp_o      out  6          FP6 product {sign, exp[1:0], man[2:0]}
//  rsp_id     out  ID_W       requester ID of rsp_o
//  busy       out  1          S1 or S2 occupied
// BEHAVIOUR
//  Reset (rst=1 at edge): s1_valid=0, s2_valid=0, rr_ptr=0, rsp_o=0, rsp_id=0.
//   Mid-operation reset drops in-flight operations; nothing emitted afterwards.
//   While rst=1, req_ready=0. rsp_valid=0 and busy=0 from the first cycle after reset.
//  Pipeline: 2 registered stages, both gated by the handshake below.
//   adv2 = !s2_valid | rsp_ready
//   adv1 = !s1_valid | adv2
//   accept = |(req_valid & req_ready)
//  Arbitration is combinational in the current cycle.
//   Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   req_ready[winner] = adv1 & !rst; all other req_ready bits are 0.
//   req_ready does not depend on req_valid of non-winners.
//  rr_ptr update:
//   On accept, rr_ptr <= (winner+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
//   rr_ptr holds when there is no accept, including under a stall.
//  S1 (when adv1):
//   s1_valid <= accept; s1_a/s1_b/s1_id <= winner operands/ID.
//   Data is don't-care when !accept.
//  S2 (when adv2):
//   s2_valid <= s1_valid; rsp_o <= fp6_mult(s1_a,s1_b); rsp_id <= s1_id.
//   rsp_o/rsp_id hold when !adv2 or when S1 is empty.
//  Latency and throughput:
//   Accept in cycle N -> rsp_valid in cycle N+2 if there is no stall.
//   Sustained throughput is 1 result/cycle while rsp_ready=1.
//  Backpressure: when rsp_ready=0 with both stages full, adv1=0.
//   All req_ready are 0, no data is lost, and order is preserved.
//   rsp_o/rsp_id are stable while rsp_valid & !rsp_ready.
//  Simultaneous events:
//   rsp handshake plus new accept in the same cycle -> both stages shift, no bubble.
//   Single active requester -> it is granted every cycle.
//  Arithmetic: product bits come only from fp6_mult (1s/2e/3m, zero-operand rule
//   inside it); the scheduler never alters the value. busy = s1_valid | s2_valid.
//  Results are in acceptance order; no reordering, no per-requester queues.
// TESTING
//  1 Reset: drive rst for 3 cycles with all req_valid=1
//    -> req_ready=0, rsp_valid=0, busy=0; first grant after rst drops goes to requester 0.
//  2 Round-robin: req_valid=4'b1111 held, rsp_ready=1
//    -> grants 0,1,2,3,0,...; rsp_id follows the same sequence with 2-cycle latency.
//  3 Skip and wrap: req_valid=4'b1010, rr_ptr=2
//    -> grant 3, then 1, then 3; rr_ptr wraps 3 -> 0 correctly.
//  4 Backpressure: fill pipe, hold rsp_ready=0 for 5 cycles
//    -> req_ready=0, rsp_o/rsp_id stable; on release, results follow in accept order.
//  5 Datapath: A=6'h00,B=6'h00 -> rsp_o=6'h00.
//    Random A/B via requester 2 -> rsp_o equals standalone fp6_mult(A,B), rsp_id=2.
//  6 Mid-op reset: assert rst with S1 and S2 full
//    -> next cycle rsp_valid=0, busy=0; the dropped results never appear.

Source files
------------

// File: rtl/fp6_mult_rr_scheduler.sv
// Round-robin scheduler sharing one FP6 (1s/2e/3m, bias 1, subnormals, saturating) multiplier
// among NUM_REQ requesters through a two-stage valid/ready pipeline with ID-tagged results.

module fp6_mult (
   input  logic [5:0] a,
   input  logic [5:0] b,
   output logic [5:0] p
);

   // Magnitude in units of 1/8: subnormal m, else (8+m) << (e-1).
   function automatic logic [5:0] mag8(input logic [4:0] em);
      logic [5:0] m;
      case (em[4:3])
         2'd0:    m = {3'b000, em[2:0]};
         2'd1:    m = {3'b001, em[2:0]};
         2'd2:    m = {2'b01, em[2:0], 1'b0};
         2'd3:    m = {1'b1, em[2:0], 2'b00};
         default: m = 6'd0;
      endcase
      return m;
   endfunction

   logic [11:0] prod_s;
   logic        up_hi_s;
   logic        up_mid_s;
   logic        up_lo_s;
   logic [6:0]  q_hi_s;
   logic [4:0]  q_mid_s;
   logic [4:0]  q_lo_s;
   logic [4:0]  em_s;

   // Exact product in 1/64 units, rounded to nearest-even on the grid of each binade, saturating at 7.5.
   always_comb begin
      prod_s   = {6'd0, mag8(a[4:0])} * {6'd0, mag8(b[4:0])};
      up_hi_s  = prod_s[4] & ((|prod_s[3:0]) | prod_s[5]);
      up_mid_s = prod_s[3] & ((|prod_s[2:0]) | prod_s[4]);
      up_lo_s  = prod_s[2] & ((|prod_s[1:0]) | prod_s[3]);
      q_hi_s   = prod_s[11:5] + {6'd0, up_hi_s};
      q_mid_s  = {1'b0, prod_s[7:4]} + {4'd0, up_mid_s};
      q_lo_s   = {1'b0, prod_s[6:3]} + {4'd0, up_lo_s};
      em_s     = 5'd0;
      if ((a[4:0] == 5'd0) || (b[4:0] == 5'd0)) begin
         em_s = 5'd0;
      end else if (prod_s >= 12'd256) begin
         if (q_hi_s > 7'd15) em_s = 5'b11111;
         else                em_s = {2'b11, q_hi_s[2:0]};
      end else if (prod_s >= 12'd128) begin
         if (q_mid_s == 5'd16) em_s = 5'b11000;
         else                  em_s = {2'b10, q_mid_s[2:0]};
      end else begin
         if (q_lo_s == 5'd16)     em_s = 5'b10000;
         else if (q_lo_s >= 5'd8) em_s = {2'b01, q_lo_s[2:0]};
         else                     em_s = {2'b00, q_lo_s[2:0]};
      end
      if (em_s == 5'd0) p = 6'd0;
      else              p = {a[5] ^ b[5], em_s};
   end

endmodule

module fp6_mult_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*6-1:0] req_a,
   input  logic [NUM_REQ*6-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [5:0]           rsp_o,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 busy
);

   logic            s1_valid_r;
   logic [5:0]      s1_a_r;
   logic [5:0]      s1_b_r;
   logic [ID_W-1:0] s1_id_r;
   logic            s2_valid_r;
   logic [5:0]      rsp_o_r;
   logic [ID_W-1:0] rsp_id_r;
   logic [ID_W-1:0] rr_ptr_r;

   logic            adv1_s;
   logic            adv2_s;
   logic            accept_s;
   logic            win_found_s;
   logic            hit_s;
   logic [ID_W-1:0] win_id_s;
   logic [ID_W-1:0] next_ptr_s;
   logic [5:0]      win_a_s;
   logic [5:0]      win_b_s;
   logic [5:0]      mult_s;
   int              idx_s;

   // Scan requesters starting at rr_ptr; the first valid one wins.
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = {ID_W{1'b0}};
      hit_s       = 1'b0;
      idx_s       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s       = int'(rr_ptr_r) + k;
         idx_s       = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
         hit_s       = !win_found_s && req_valid[idx_s];
         win_id_s    = hit_s ? ID_W'(idx_s) : win_id_s;
         win_found_s = win_found_s || hit_s;
      end
   end

   // Handshake, grant and operand selection for the current cycle.
   always_comb begin
      adv2_s    = !s2_valid_r || rsp_ready;
      adv1_s    = !s1_valid_r || adv2_s;
      req_ready = {NUM_REQ{1'b0}};
      if (win_found_s && adv1_s && !rst) begin
         req_ready[win_id_s] = 1'b1;
      end else begin
         req_ready = {NUM_REQ{1'b0}};
      end
      accept_s = |(req_valid & req_ready);
      win_a_s  = req_a[6*int'(win_id_s) +: 6];
      win_b_s  = req_b[6*int'(win_id_s) +: 6];
      if (win_id_s == ID_W'(NUM_REQ - 1)) begin
         next_ptr_s = {ID_W{1'b0}};
      end else begin
         next_ptr_s = win_id_s + ID_W'(1);
      end
   end

   fp6_mult u_mult (
      .a (s1_a_r),
      .b (s1_b_r),
      .p (mult_s)
   );

   // Pipeline stages and round-robin pointer; results hold unless a valid S1 moves forward.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= 6'd0;
         s1_b_r     <= 6'd0;
         s1_id_r    <= {ID_W{1'b0}};
         s2_valid_r <= 1'b0;
         rsp_o_r    <= 6'd0;
         rsp_id_r   <= {ID_W{1'b0}};
         rr_ptr_r   <= {ID_W{1'b0}};
      end else begin
         if (adv1_s) begin
            s1_valid_r <= accept_s;
            s1_a_r     <= win_a_s;
            s1_b_r     <= win_b_s;
            s1_id_r    <= win_id_s;
         end
         if (adv2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               rsp_o_r  <= mult_s;
               rsp_id_r <= s1_id_r;
            end
         end
         if (accept_s) begin
            rr_ptr_r <= next_ptr_s;
         end
      end
   end

   assign rsp_valid = s2_valid_r;
   assign rsp_o     = rsp_o_r;
   assign rsp_id    = rsp_id_r;
   assign busy      = s1_valid_r | s2_valid_r;

endmodule

// File: tb/tb_fp6_mult_rr_scheduler.sv
// Randomized scoreboard bench for fp6_mult_rr_scheduler against a value-level FP6 reference.

module tb_fp6_mult_rr_scheduler;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*6-1:0] req_a;
   logic [N*6-1:0] req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [5:0]    rsp_o;
   logic [IW-1:0] rsp_id;
   logic          busy;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [5:0]    p;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bit   armed = 1'b0;
   bit   m1 = 1'b0;
   bit   m2 = 1'b0;
   int   rr = 0;

   always #5 clk = ~clk;

   fp6_mult_rr_scheduler #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_o     (rsp_o),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   function automatic real fp_mag(input logic [4:0] em);
      int e = int'(em[4:3]);
      int m = int'(em[2:0]);
      if (e == 0) return m / 8.0;
      return (1.0 + m / 8.0) * (1 << (e - 1));
   endfunction

   // Nearest representable magnitude (ties to even mantissa), largest finite on overflow.
   function automatic logic [5:0] ref_mult(input logic [5:0] a, input logic [5:0] b);
      real pr, d, bd;
      logic [4:0] best;
      logic [4:0] em;
      pr = fp_mag(a[4:0]) * fp_mag(b[4:0]);
      best = 5'd0;
      bd = pr;
      for (int i = 1; i < 32; i++) begin
         em = 5'(i);
         d = fp_mag(em) - pr;
         if (d < 0.0) d = -d;
         if (d < bd || (d == bd && em[0] == 1'b0 && best[0] == 1'b1)) begin
            best = em;
            bd = d;
         end
      end
      if (best == 5'd0) return 6'd0;
      return {a[5] ^ b[5], best};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [N-1:0] v, input logic rdy);
      req_valid = v;
      rsp_ready = rdy;
      req_a = 24'($urandom());
      req_b = 24'($urandom());
      @(negedge clk);
   endtask

   // Reference model: predicts grants, pipeline occupancy and queued results just before each edge.
   initial begin
      logic [N-1:0] exp_ready;
      bit found, adv1, adv2, acc;
      int win, idx;
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         adv2 = !m2 || rsp_ready;
         adv1 = !m1 || adv2;
         found = 1'b0;
         win = 0;
         for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               win = idx;
            end
         end
         exp_ready = '0;
         if (found && adv1 && !rst) exp_ready[win] = 1'b1;
         acc = found && adv1 && !rst;
         if (armed) begin
            chk("req_ready", int'(req_ready), int'(exp_ready));
            chk("rsp_valid", int'(rsp_valid), int'(m2));
            chk("busy", int'(busy), int'(m1 | m2));
         end
         if (rst) begin
            armed = 1'b1;
            m1 = 1'b0;
            m2 = 1'b0;
            rr = 0;
            sb.delete();
         end else begin
            if (acc) begin
               e.id = IW'(win);
               e.p = ref_mult(req_a[6*win +: 6], req_b[6*win +: 6]);
               sb.push_back(e);
               rr = (win + 1) % N;
            end
            if (adv2) m2 = m1;
            if (adv1) m1 = acc;
         end
      end
   end

   // Monitor: compare every result handshake with the head of the scoreboard; check stall stability.
   initial begin
      bit held = 1'b0;
      logic [5:0] held_o;
      logic [IW-1:0] held_id;
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (armed && !rst) begin
            if (held && rsp_valid) begin
               chk("stall_rsp_o", int'(rsp_o), int'(held_o));
               chk("stall_rsp_id", int'(rsp_id), int'(held_id));
            end
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  chk("rsp_unexpected", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", int'(rsp_id), int'(e.id));
                  chk("rsp_o", int'(rsp_o), int'(e.p));
               end
            end
            held = rsp_valid && !rsp_ready;
            held_o = rsp_o;
            held_id = rsp_id;
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      rst = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      req_a = '0;
      req_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (12) step(4'b1111, 1'b1);
      repeat (6) step(4'b1010, 1'b1);
      repeat (2) step(4'b1111, 1'b1);
      repeat (5) step(4'b1111, 1'b0);
      repeat (4) step(4'b1111, 1'b1);
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      req_a = 24'($urandom());
      req_b = 24'($urandom());
      req_a[17:12] = 6'h00;
      req_b[17:12] = 6'h00;
      @(negedge clk);
      repeat (20) step(4'b0100, 1'b1);
      for (int i = 0; i < 4096; i++) begin
         req_valid = 4'b0100;
         rsp_ready = 1'b1;
         req_a[17:12] = 6'(i >> 6);
         req_b[17:12] = 6'(i);
         @(negedge clk);
      end
      for (int i = 0; i < 300; i++) begin
         step(4'($urandom()), ($urandom_range(0, 3) != 0));
      end
      repeat (3) step(4'b1111, 1'b0);
      rst = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) step(4'b0000, 1'b1);
      repeat (20) step(4'($urandom()), 1'b1);
      repeat (4) step(4'b0000, 1'b1);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
